// File: rtl/uart_tx_engine_if.sv
// Host-side bundle for uart_tx_engine: frame request, word, framing config and line status.
// UART_TX_BREAK_EN adds the tx_break request line.
interface uart_tx_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  parity_en;
    logic                  parity_odd;
    logic                  two_stop;
`ifdef UART_TX_BREAK_EN
    logic                  tx_break;
`endif
    logic                  tx;
    logic                  tx_busy;
    logic                  tx_done;

`ifdef UART_TX_BREAK_EN
    modport master (
        output tx_start, tx_data, parity_en, parity_odd, two_stop, tx_break,
        input  tx, tx_busy, tx_done
    );

    modport slave (
        input  tx_start, tx_data, parity_en, parity_odd, two_stop, tx_break,
        output tx, tx_busy, tx_done
    );
`else
    modport master (
        output tx_start, tx_data, parity_en, parity_odd, two_stop,
        input  tx, tx_busy, tx_done
    );

    modport slave (
        input  tx_start, tx_data, parity_en, parity_odd, two_stop,
        output tx, tx_busy, tx_done
    );
`endif
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, DATA_WIDTH data bits LSB first, optional parity, one or two stops.
// Define UART_TX_BREAK_EN to add the tx_break input and the BREAK (line held low) state.
module uart_tx_engine #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_engine_if.slave bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
        , ST_BREAK = 3'd5
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  parity_q, parity_d;
    logic                  par_en_q, par_en_d;
    logic                  two_stop_q, two_stop_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  bit_end;
    logic                  brk_active;

`ifdef UART_TX_BREAK_EN
    logic                  brk_q, brk_d;
    assign brk_active = brk_q;
`else
    assign brk_active = 1'b0;
`endif

    assign bit_end = (baud_q == BAUD_LAST);

    // Every transition happens on a bit end, so wrapping the counter there also restarts it on state entry.
    always_comb begin
        state_d    = state_q;
        baud_d     = bit_end ? '0 : baud_q + 1'b1;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_d      = brk_q;
`endif

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
`ifdef UART_TX_BREAK_EN
                brk_d  = 1'b0;
                if (bus.tx_break) begin
                    state_d = ST_BREAK;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    brk_d   = 1'b1;
                end else
`endif
                if (bus.tx_start) begin
                    state_d    = ST_START;
                    shreg_d    = bus.tx_data;
                    parity_d   = (^bus.tx_data) ^ bus.parity_odd;
                    par_en_d   = bus.parity_en;
                    two_stop_d = bus.two_stop;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    bit_d   = '0;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end

            // bit_q counts stop bits here; a break always finishes with a single silent stop bit.
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (two_stop_q && !brk_active && (bit_q == '0)) begin
                        bit_d = bit_q + 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = !brk_active;
                        bit_d   = '0;
                    end
                end
            end

`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                tx_d = 1'b0;
                if (bit_end && !bus.tx_break) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_BREAK_EN
            brk_q      <= brk_d;
`endif
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Randomised bench for uart_tx_engine: a queue-of-line-levels frame model checked every cycle,
// plus literal frame expectations; the break test is included when UART_TX_BREAK_EN is defined.
module tb_uart_tx_engine;
    localparam int DW  = 8;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_engine_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_engine #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    logic exp_tx   = 1'b1;
    logic exp_busy = 1'b0;
    logic exp_done = 1'b0;
    logic brk_mode = 1'b0;
    logic brk_stop = 1'b0;
    logic line_q[$];
    int   busy_len = 0;
    int   done_cnt = 0;
    logic cap[0:255];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    function automatic void push_bit(input logic v);
        for (int i = 0; i < CPB; i++) line_q.push_back(v);
    endfunction

    // A frame is just the list of line levels it puts on tx, one bit time per entry.
    function automatic void push_frame(input logic [DW-1:0] d, input logic pe, input logic po,
                                       input logic ts);
        push_bit(1'b0);
        for (int i = 0; i < DW; i++) push_bit(d[i]);
        if (pe) push_bit((^d) ^ po);
        push_bit(1'b1);
        if (ts) push_bit(1'b1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            brk_mode = 1'b0;
            brk_stop = 1'b0;
        end else begin
            cyc++;
            if (exp_busy) begin
                exp_done = 1'b0;
`ifdef UART_TX_BREAK_EN
                if (line_q.size() == 0 && brk_mode) begin
                    if (bus.tx_break) push_bit(1'b0);
                    else begin
                        push_bit(1'b1);
                        brk_mode = 1'b0;
                        brk_stop = 1'b1;
                    end
                end
`endif
                if (line_q.size() != 0) exp_tx = line_q.pop_front();
                else begin
                    exp_tx   = 1'b1;
                    exp_busy = 1'b0;
                    exp_done = !brk_stop;
                    brk_stop = 1'b0;
                end
            end else begin
                exp_done = 1'b0;
                exp_tx   = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (bus.tx_break) begin
                    brk_mode = 1'b1;
                    push_bit(1'b0);
                end else
`endif
                if (bus.tx_start)
                    push_frame(bus.tx_data, bus.parity_en, bus.parity_odd, bus.two_stop);
                if (line_q.size() != 0) begin
                    exp_tx   = line_q.pop_front();
                    exp_busy = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("tx", bus.tx, exp_tx);
            checkOutput("tx_busy", bus.tx_busy, exp_busy);
            checkOutput("tx_done", bus.tx_done, exp_done);
        end
    end

    always @(negedge clk) begin
        if (bus.tx_busy) begin
            if (busy_len < 256) cap[busy_len] = bus.tx;
            busy_len++;
        end
        if (bus.tx_done) done_cnt++;
    end

    task automatic clearMonitor();
        @(posedge clk);
        #1;
        busy_len = 0;
        done_cnt = 0;
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.tx_busy && n < limit);
        if (bus.tx_busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: tx_busy still 1 after %0d cycles, expected 0", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input logic pe, input logic po,
                                 input logic ts);
        clearMonitor();
        @(negedge clk);
        bus.tx_data    = d;
        bus.parity_en  = pe;
        bus.parity_odd = po;
        bus.two_stop   = ts;
        bus.tx_start   = 1'b1;
        @(negedge clk);
        bus.tx_start   = 1'b0;
        bus.tx_data    = DW'($urandom);
        bus.parity_en  = 1'($urandom_range(0, 1));
        bus.parity_odd = 1'($urandom_range(0, 1));
        bus.two_stop   = 1'($urandom_range(0, 1));
        waitIdle(400);
    endtask

    function automatic logic [15:0] sample_bits(input int n);
        logic [15:0] r = '0;
        for (int i = 0; i < n; i++) r[i] = cap[i*CPB + CPB/2];
        return r;
    endfunction

    function automatic int count_ones(input int from, input int to);
        int c = 0;
        for (int i = from; i <= to; i++) if (cap[i] === 1'b1) c++;
        return c;
    endfunction

    initial begin
        bus.tx_start   = 1'b0;
        bus.tx_data    = '0;
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
        bus.two_stop   = 1'b0;
`ifdef UART_TX_BREAK_EN
        bus.tx_break   = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", bus.tx, 1);
        checkOutput("reset_busy", bus.tx_busy, 0);
        checkOutput("reset_done", bus.tx_done, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0);
        checkOutput("a5_busy_len", busy_len, 40);
        checkOutput("a5_done_cnt", done_cnt, 1);
        checkOutput("a5_bits", int'(sample_bits(10)), 16'b0000_0011_0100_1010);

        applyStimulus(8'h07, 1'b1, 1'b0, 1'b0);
        checkOutput("even_busy_len", busy_len, 44);
        checkOutput("even_parity_bit", cap[9*CPB + 2], 1);

        applyStimulus(8'h07, 1'b1, 1'b1, 1'b0);
        checkOutput("odd_busy_len", busy_len, 44);
        checkOutput("odd_parity_bit", cap[9*CPB + 2], 0);

        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("two_stop_busy_len", busy_len, 48);
        checkOutput("two_stop_done_cnt", done_cnt, 1);
        checkOutput("two_stop_high_cycles", count_ones(40, 47), 8);

        // tx_start held for 83 sampling edges: accepts at 0, 41 and 82 only.
        clearMonitor();
        @(negedge clk);
        bus.parity_en = 1'b0;
        bus.two_stop  = 1'b0;
        bus.tx_start  = 1'b1;
        repeat (83) begin
            bus.tx_data = DW'($urandom);
            @(negedge clk);
        end
        bus.tx_start = 1'b0;
        waitIdle(400);
        checkOutput("b2b_done_cnt", done_cnt, 3);
        checkOutput("b2b_busy_len", busy_len, 120);

        // Reset lands in the middle of data bit 3 of an all-zero word.
        clearMonitor();
        @(negedge clk);
        bus.tx_data   = 8'h00;
        bus.parity_en = 1'b0;
        bus.two_stop  = 1'b0;
        bus.tx_start  = 1'b1;
        @(negedge clk);
        bus.tx_start  = 1'b0;
        repeat (17) @(negedge clk);
        checkOutput("pre_reset_tx", bus.tx, 0);
        checkOutput("pre_reset_busy", bus.tx_busy, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_reset_tx", bus.tx, 1);
        checkOutput("async_reset_busy", bus.tx_busy, 0);
        checkOutput("async_reset_done", bus.tx_done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("post_reset_idle_tx", bus.tx, 1);
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0);
        checkOutput("post_reset_busy_len", busy_len, 40);
        checkOutput("post_reset_bits", int'(sample_bits(10)), 16'b0000_0011_0100_1010);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.tx_start   = ($urandom_range(0, 2) == 0);
            bus.tx_data    = DW'($urandom);
            bus.parity_en  = 1'($urandom_range(0, 1));
            bus.parity_odd = 1'($urandom_range(0, 1));
            bus.two_stop   = 1'($urandom_range(0, 1));
`ifdef UART_TX_BREAK_EN
            bus.tx_break   = ($urandom_range(0, 19) == 0);
`endif
        end
        @(negedge clk);
        bus.tx_start = 1'b0;
`ifdef UART_TX_BREAK_EN
        bus.tx_break = 1'b0;
`endif
        waitIdle(400);

`ifdef UART_TX_BREAK_EN
        clearMonitor();
        @(negedge clk);
        bus.tx_break = 1'b1;
        repeat (10) @(negedge clk);
        bus.tx_break = 1'b0;
        waitIdle(400);
        checkOutput("break_busy_len", busy_len, 16);
        checkOutput("break_done_cnt", done_cnt, 0);
        checkOutput("break_low_cycles", 16 - count_ones(0, 15), 12);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
